// File: rtl/data_memory_ctrl_pkg.sv
// Shared definitions for the MEM-stage data memory.
// FUNC3 width codes and the controller state encoding.
package data_memory_ctrl_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for word memory: store enables/shift, load align.
// Ports: func3, is_write, addr_lo, store_data, read_word -> byte_en, store_shift, load_data, legal.
module mem_lane_align
  import data_memory_ctrl_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic        is_write,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] read_word,
  output logic [3:0]  byte_en,
  output logic [31:0] store_shift,
  output logic [31:0] load_data,
  output logic        legal
);

  logic [4:0]  sh;
  logic [31:0] rd_sh;

  assign sh          = {addr_lo, 3'b000};
  assign rd_sh       = read_word >> sh;
  assign store_shift = store_data << sh;

  always_comb begin
    byte_en   = 4'b0000;
    load_data = 32'h0;
    legal     = 1'b0;
    unique case (func3)
      F3_LB: begin
        byte_en   = 4'b0001 << addr_lo;
        load_data = {24'h0, rd_sh[7:0]};
        legal     = 1'b1;
      end
      F3_LBU: begin
        byte_en   = 4'b0001 << addr_lo;
        load_data = {24'h0, rd_sh[7:0]};
        legal     = !is_write;
      end
      F3_LH: begin
        byte_en   = 4'b0011 << addr_lo;
        load_data = {16'h0, rd_sh[15:0]};
        legal     = !addr_lo[0];
      end
      F3_LHU: begin
        byte_en   = 4'b0011 << addr_lo;
        load_data = {16'h0, rd_sh[15:0]};
        legal     = !is_write && !addr_lo[0];
      end
      F3_LW: begin
        byte_en   = 4'b1111;
        load_data = read_word;
        legal     = (addr_lo == 2'b00);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// Multi-cycle word data memory for the MEM stage with stall and error.
// Ports: CLK, RESET(n), READ, WRITE, FUNC3, ADDRESS, WRITEDATA -> READDATA, BUSYWAIT, ERROR.
module data_memory_ctrl
  import data_memory_ctrl_pkg::*;
#(
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 4
)(
  input  logic        CLK,
  input  logic        RESET,
  input  logic        READ,
  input  logic        WRITE,
  input  logic [2:0]  FUNC3,
  input  logic [31:0] ADDRESS,
  input  logic [31:0] WRITEDATA,
  output logic [31:0] READDATA,
  output logic        BUSYWAIT,
  output logic        ERROR
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam int CW    = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  state_t               state;
  logic [CW-1:0]        cnt;
  logic                 req_wr;
  logic [2:0]           req_f3;
  logic [ADDR_BITS+1:0] req_addr;
  logic [31:0]          req_wdata;

  logic [31:0] mem [DEPTH];

  logic                 in_idle;
  logic                 req_in;
  logic                 last;
  logic                 mem_we;
  logic [ADDR_BITS-1:0] idx;
  logic [2:0]           sel_f3;
  logic                 sel_wr;
  logic [1:0]           sel_lo;
  logic [3:0]           byte_en;
  logic [31:0]          store_shift;
  logic [31:0]          load_data;
  logic                 legal;
  logic                 addr_unused;

  // High address bits are dropped on purpose: addresses wrap.
  assign addr_unused = ^ADDRESS[31:ADDR_BITS+2];

  assign in_idle = (state == ST_IDLE);
  assign req_in  = READ | WRITE;
  assign last    = (state == ST_ACCESS) && (cnt == '0);
  assign mem_we  = last && req_wr;
  assign idx     = req_addr[ADDR_BITS+1:2];

  // Legality is judged on live inputs in IDLE; the access uses latched copies.
  assign sel_f3 = in_idle ? FUNC3 : req_f3;
  assign sel_wr = in_idle ? WRITE : req_wr;
  assign sel_lo = in_idle ? ADDRESS[1:0] : req_addr[1:0];

  assign BUSYWAIT = (in_idle && req_in) || (state == ST_ACCESS);

  mem_lane_align u_align (
    .func3       (sel_f3),
    .is_write    (sel_wr),
    .addr_lo     (sel_lo),
    .store_data  (req_wdata),
    .read_word   (mem[idx]),
    .byte_en     (byte_en),
    .store_shift (store_shift),
    .load_data   (load_data),
    .legal       (legal)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      req_wr    <= 1'b0;
      req_f3    <= 3'b000;
      req_addr  <= '0;
      req_wdata <= 32'h0;
      READDATA  <= 32'h0;
      ERROR     <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          ERROR <= 1'b0;
          if (req_in) begin
            req_wr    <= WRITE;
            req_f3    <= FUNC3;
            req_addr  <= ADDRESS[ADDR_BITS+1:0];
            req_wdata <= WRITEDATA;
            if (legal) begin
              state <= ST_ACCESS;
              cnt   <= CNT_INIT;
            end else begin
              state    <= ST_DONE;
              ERROR    <= 1'b1;
              READDATA <= 32'h0;
            end
          end
        end
        ST_ACCESS: begin
          if (cnt == '0) begin
            state <= ST_DONE;
            if (!req_wr)
              READDATA <= load_data;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_DONE: begin
          ERROR <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Array has no reset; state is forced to IDLE by reset so no write fires.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b])
          mem[idx][b*8 +: 8] <= store_shift[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Scoreboard bench for data_memory_ctrl against a byte-array model.
// Driver pushes expectations; a negedge monitor checks each DONE cycle.
module tb_data_memory_ctrl;

  localparam int AB  = 8;
  localparam int LAT = 4;
  localparam int NB  = 4 << AB;

  logic        CLK;
  logic        RESET;
  logic        READ;
  logic        WRITE;
  logic [2:0]  FUNC3;
  logic [31:0] ADDRESS;
  logic [31:0] WRITEDATA;
  logic [31:0] READDATA;
  logic        BUSYWAIT;
  logic        ERROR;

  data_memory_ctrl #(.ADDR_BITS(AB), .LATENCY(LAT)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .READ      (READ),
    .WRITE     (WRITE),
    .FUNC3     (FUNC3),
    .ADDRESS   (ADDRESS),
    .WRITEDATA (WRITEDATA),
    .READDATA  (READDATA),
    .BUSYWAIT  (BUSYWAIT),
    .ERROR     (ERROR)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    int          busy;
    logic        err;
    logic [31:0] rd;
  } exp_t;

  exp_t        sbq[$];
  logic [7:0]  mb [NB];
  logic [31:0] last_rd;
  int          total;
  int          bad;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference: memory is a flat byte array; requests are judged by width rules.
  function automatic exp_t model(bit wr, logic [2:0] f3,
                                 logic [31:0] a, logic [31:0] wd);
    exp_t        e;
    int          n;
    bit          ok;
    int          base;
    logic [31:0] v;
    if (f3[1:0] == 2'd0)      n = 1;
    else if (f3[1:0] == 2'd1) n = 2;
    else                      n = 4;
    ok = !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    if (wr && f3[2]) ok = 0;
    if ((int'(a[1:0]) % n) != 0) ok = 0;
    base = int'(a) % NB;
    if (base < 0) base = base + NB;
    base = int'(a[AB+1:0]);
    if (!ok) begin
      last_rd = 32'h0;
    end else if (wr) begin
      for (int i = 0; i < n; i++)
        mb[(base + i) % NB] = wd[8*i +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < n; i++)
        v[8*i +: 8] = mb[(base + i) % NB];
      last_rd = v;
    end
    e.busy = ok ? LAT + 1 : 1;
    e.err  = !ok;
    e.rd   = last_rd;
    return e;
  endfunction

  task automatic issue(bit rd, bit wr, logic [2:0] f3,
                       logic [31:0] a, logic [31:0] wd);
    int n;
    sbq.push_back(model(wr, f3, a, wd));
    @(posedge CLK);
    #1;
    READ      = rd;
    WRITE     = wr;
    FUNC3     = f3;
    ADDRESS   = a;
    WRITEDATA = wd;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (BUSYWAIT && n < 50);
    if (BUSYWAIT) begin
      total++;
      bad++;
      $display("FAIL busy_timeout got=1 want=0 t=%0t", $time);
    end
    @(posedge CLK);
    #1;
    READ  = 1'b0;
    WRITE = 1'b0;
  endtask

  // Monitor: a BUSYWAIT fall marks the DONE cycle of a request.
  int  bcnt;
  bit  prev_busy;
  always @(negedge CLK) begin
    exp_t e;
    if (!RESET) begin
      bcnt      = 0;
      prev_busy = 0;
    end else begin
      if (BUSYWAIT) begin
        bcnt++;
        chk("error_while_busy", 32'(ERROR), 32'h0);
      end else if (prev_busy) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done got=1 want=0 t=%0t", $time);
        end else begin
          e = sbq.pop_front();
          chk("busy_cycles", 32'(bcnt), 32'(e.busy));
          chk("error", 32'(ERROR), 32'(e.err));
          chk("readdata", READDATA, e.rd);
        end
        bcnt = 0;
      end else begin
        chk("error_idle", 32'(ERROR), 32'h0);
      end
      prev_busy = BUSYWAIT;
    end
  end

  initial begin
    int          k;
    logic [31:0] a;
    total     = 0;
    bad       = 0;
    last_rd   = 32'h0;
    RESET     = 1'b0;
    READ      = 1'b0;
    WRITE     = 1'b0;
    FUNC3     = 3'b000;
    ADDRESS   = 32'h0;
    WRITEDATA = 32'h0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_readdata", READDATA, 32'h0);
    chk("rst_error", 32'(ERROR), 32'h0);
    chk("rst_busy", 32'(BUSYWAIT), 32'h0);
    RESET = 1'b1;

    for (int w = 0; w < 16; w++)
      issue(0, 1, 3'b010, 32'(w * 4), $urandom);

    issue(0, 1, 3'b010, 32'h10, 32'hAABBCCDD);
    issue(1, 0, 3'b010, 32'h10, 32'h0);
    issue(0, 1, 3'b000, 32'h13, 32'h000000EE);
    issue(1, 0, 3'b010, 32'h10, 32'h0);
    issue(0, 1, 3'b001, 32'h12, 32'h00001234);
    issue(1, 0, 3'b010, 32'h10, 32'h0);
    issue(1, 0, 3'b000, 32'h11, 32'h0);
    issue(1, 0, 3'b101, 32'h12, 32'h0);
    issue(1, 0, 3'b001, 32'h11, 32'h0);
    issue(0, 1, 3'b010, 32'h12, 32'h0BADF00D);
    issue(1, 0, 3'b010, 32'h10, 32'h0);
    issue(1, 0, 3'b011, 32'h10, 32'h0);
    issue(0, 1, 3'b100, 32'h10, 32'h11);
    issue(1, 0, 3'b010, 32'h10, 32'h0);

    // Reset in the 2nd ACCESS cycle of a store: the write must not land.
    @(posedge CLK);
    #1;
    WRITE     = 1'b1;
    FUNC3     = 3'b010;
    ADDRESS   = 32'h20;
    WRITEDATA = 32'hFFFFFFFF;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    WRITE = 1'b0;
    #1;
    chk("abort_busy", 32'(BUSYWAIT), 32'h0);
    chk("abort_readdata", READDATA, 32'h0);
    chk("abort_error", 32'(ERROR), 32'h0);
    last_rd = 32'h0;
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    issue(1, 0, 3'b010, 32'h20, 32'h0);

    issue(1, 1, 3'b010, 32'h30, 32'h5A5A5A5A);
    issue(1, 0, 3'b010, 32'h30, 32'h0);
    issue(1, 0, 3'b010, 32'h30 + (32'd4 << AB), 32'h0);

    for (int i = 0; i < 200; i++) begin
      k = $urandom_range(0, 2);
      a = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 63));
      issue(k != 1, k != 0, 3'($urandom_range(0, 7)), a, $urandom);
    end

    k = 0;
    while (sbq.size() != 0 && k < 20) begin
      @(negedge CLK);
      k++;
    end
    chk("queue_drained", 32'(sbq.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
Word-organised data memory with multi-cycle access latency, for the MEM stage of the RISC-V pipeline.
- Upstream: the load/store data-correction logic, which supplies store data zero-extended into the low byte/half of WRITEDATA and expects load data delivered right-aligned (addressed byte/half in bits [7:0]/[15:0]).
- Lane work done here: shifts store data into the addressed byte lanes, right-aligns loaded data by address offset, and stalls the pipeline with BUSYWAIT.
- Checks alignment and FUNC3 legality.

Parameters:
- ADDR_BITS, 8, word-index width; depth = 2**ADDR_BITS words.
- LATENCY, 4, number of ACCESS-state cycles per legal request (>=1).

Ports:
- CLK  input  1  rising-edge clock
- RESET  input  1  asynchronous, active-low reset
- READ  input  1  load request
- WRITE  input  1  store request
- FUNC3  input  3  access width: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu (stores use 000/001/010)
- ADDRESS  input  32  byte address
- WRITEDATA  input  32  store data, right-aligned
- READDATA  output  32  right-aligned, unextended word/half/byte
- BUSYWAIT  output  1  pipeline stall
- ERROR  output  1  one-cycle pulse: misaligned or illegal request

Behaviour:
- Interface: one clock CLK; reset RESET is asynchronous and active-low.
- States: IDLE, ACCESS, DONE.
- Reset (RESET=0): immediately go to IDLE; READDATA=0, ERROR=0, counter=0, latched request cleared.
  - Array contents are not reset.
  - An in-flight write is aborted and the array is unmodified.
  - BUSYWAIT follows its combinational equation, so it reasserts at once if READ/WRITE is still high.
- BUSYWAIT = (state==IDLE && (READ||WRITE)) || state==ACCESS. It is low in DONE.
- IDLE, READ or WRITE high at an edge: latch op, FUNC3, ADDRESS, WRITEDATA.
  - If both are high, the request is a write; READ is ignored.
  - Legal request: go to ACCESS with counter=LATENCY-1.
  - Illegal request: go directly to DONE with ERROR=1 and READDATA=0. No array access.
- Illegal requests:
  - FUNC3 in {011, 110, 111}.
  - Write with FUNC3 in {100, 101}.
  - Half access with ADDRESS[0]=1.
  - Word access with ADDRESS[1:0]!=0.
- ACCESS: decrement the counter each edge. At the edge where counter==0, go to DONE and perform the access.
  - Read: READDATA <= mem[idx] >> (8*ADDRESS[1:0]), masked to the access width (byte: [7:0], half: [15:0], upper bits zero; word: unmasked).
  - Write: byte enables = 0001/0011/1111 << ADDRESS[1:0]; store data = WRITEDATA << (8*ADDRESS[1:0]). Only enabled lanes are written.
- idx = ADDRESS[ADDR_BITS+1:2]. Higher address bits are ignored, so addresses wrap.
- Inputs are ignored while in ACCESS or DONE; the latched copies are used.
- DONE: lasts exactly one cycle, then goes to IDLE.
  - READDATA holds until the next completed read or reset.
  - ERROR is high only in DONE for illegal requests.
  - A request still asserted in the following IDLE cycle is treated as a new request. The pipeline advances on the DONE edge, so this is a genuine next access.
- Timing: legal request seen in cycle 0 → BUSYWAIT high for cycles 0..LATENCY, low in cycle LATENCY+1 (DONE). Illegal request → BUSYWAIT high in cycle 0 only.

Decomposition:
- Shared package/header: FUNC3 width codes (LB, LH, LW, LBU, LHU, SB, SH, SW) and the state encoding.
- Sub-module mem_lane_align (combinational), reused by the pipeline's forwarding checks. Inputs: FUNC3, ADDRESS[1:0], store data, read word. Outputs: byte enables, shifted store data, right-aligned load data, legality flag.
- The state machine and array live in data_memory_ctrl.

Test Plan:
- Reset, then sw FUNC3=010 ADDRESS=0x10 WRITEDATA=0xAABBCCDD, LATENCY=4 → BUSYWAIT high 5 cycles, low in 6th; a following lw at 0x10 returns READDATA=0xAABBCCDD after the same 5-cycle stall.
- sb ADDRESS=0x13 WRITEDATA=0x000000EE, then lw 0x10 → 0xEEBBCCDD; sh ADDRESS=0x12 WRITEDATA=0x00001234 then lw → 0x1234CCDD.
- lb ADDRESS=0x11 on word 0x1234CCDD → READDATA=0x000000CC; lhu ADDRESS=0x12 → 0x00001234.
- lh ADDRESS=0x11, and sw ADDRESS=0x12 → BUSYWAIT high 1 cycle, ERROR pulse 1 cycle, READDATA=0, memory word unchanged; FUNC3=011 read → same response.
- Assert RESET=0 in the 2nd ACCESS cycle of sw 0x20 0xFFFFFFFF, with READ/WRITE low at release → IDLE, BUSYWAIT low, READDATA=0, word at 0x20 retains its prior value.
- READ and WRITE both high, sw 0x30 0x5A5A5A5A → treated as a write; a later lw 0x30 returns 0x5A5A5A5A; address 0x30 + (4<<ADDR_BITS) aliases to the same word.
